musb_shift_scheduler: RTL

Shares one musb_shifter instance between two requesters: port 0 is the execute stage and port 1 is the bit-manipulation unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Operations are SRL, SLL and SRA, plus rotate-right (ROR). ROR is built as two sequenced shifter passes. Only one operation is in flight at a time.

---
 rtl/musb_defines.sv | 16 +
 rtl/musb_shifter.sv | 20 ++
 rtl/musb_shift_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/musb_defines.sv
// Shared encodings for the shifter scheduler: operation codes and FSM states.
package musb_defines;

   localparam logic [1:0] SHOP_SRL = 2'b00;
   localparam logic [1:0] SHOP_SLL = 2'b01;
   localparam logic [1:0] SHOP_SRA = 2'b10;
   localparam logic [1:0] SHOP_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PASS1 = 2'b01,
      ST_PASS2 = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

endpackage

// File: rtl/musb_shifter.sv
// Combinational 32-bit barrel shifter: left when direction_i, else logical or
// arithmetic right depending on sign_extend_i.
module musb_shifter (
   input  logic [31:0] data_i,
   input  logic [4:0]  shamnt_i,
   input  logic        direction_i,
   input  logic        sign_extend_i,
   output logic [31:0] result_o
);

   always_comb begin
      if (direction_i)
         result_o = data_i << shamnt_i;
      else if (sign_extend_i)
         result_o = $unsigned($signed(data_i) >>> shamnt_i);
      else
         result_o = data_i >> shamnt_i;
   end

endmodule

// File: rtl/musb_shift_scheduler.sv
// Round-robin scheduler sharing one shifter between the execute stage (port 0)
// and the bit-manipulation unit (port 1); ROR is done as SRL then SLL passes.
module musb_shift_scheduler
   import musb_defines::*;
#(
   parameter int OP_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [31:0]     req0_data,
   input  logic [4:0]      req0_shamnt,
   input  logic [OP_W-1:0] req0_op,
   output logic            resp0_valid,
   input  logic            resp0_ready,
   output logic [31:0]     resp0_data,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [31:0]     req1_data,
   input  logic [4:0]      req1_shamnt,
   input  logic [OP_W-1:0] req1_op,
   output logic            resp1_valid,
   input  logic            resp1_ready,
   output logic [31:0]     resp1_data,
   input  logic            flush,
   output logic            busy
);

   state_e          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_grant_q, last_grant_d;
   logic [31:0]     data_q, data_d;
   logic [31:0]     partial_q, partial_d;
   logic [31:0]     resp_data_q, resp_data_d;
   logic [4:0]      shamnt_q, shamnt_d;
   logic [OP_W-1:0] op_q, op_d;

   logic            v0, grant0, grant1;
   logic [31:0]     sh_res;
   logic [4:0]      sh_amt;
   logic            sh_dir, sh_sext;

   // Second ROR pass shifts left by the complement amount and ORs in pass one.
   always_comb begin
      sh_amt  = shamnt_q;
      sh_dir  = (op_q == SHOP_SLL);
      sh_sext = (op_q == SHOP_SRA);
      if (state_q == ST_PASS2) begin
         sh_amt  = 5'd0 - shamnt_q;
         sh_dir  = 1'b1;
         sh_sext = 1'b0;
      end
   end

   musb_shifter u_shifter (
      .data_i        (data_q),
      .shamnt_i      (sh_amt),
      .direction_i   (sh_dir),
      .sign_extend_i (sh_sext),
      .result_o      (sh_res)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      partial_d    = partial_q;
      resp_data_d  = resp_data_q;
      shamnt_d     = shamnt_q;
      op_d         = op_q;
      v0           = req0_valid & ~flush;
      grant0       = 1'b0;
      grant1       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rst) begin
               grant0 = v0 & (~req1_valid | last_grant_q);
               grant1 = req1_valid & (~v0 | ~last_grant_q);
            end
            if (grant0 || grant1) begin
               data_d       = grant1 ? req1_data   : req0_data;
               shamnt_d     = grant1 ? req1_shamnt : req0_shamnt;
               op_d         = grant1 ? req1_op     : req0_op;
               owner_d      = grant1;
               last_grant_d = grant1;
               state_d      = ST_PASS1;
            end
         end
         ST_PASS1: begin
            if (op_q == SHOP_ROR && shamnt_q != 5'd0) begin
               partial_d = sh_res;
               state_d   = ST_PASS2;
            end else begin
               resp_data_d = sh_res;
               state_d     = ST_RESP;
            end
         end
         ST_PASS2: begin
            resp_data_d = partial_q | sh_res;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (owner_q ? resp1_ready : resp0_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A flushed port-0 operation leaves the result register untouched.
      if (flush && !owner_q && state_q != ST_IDLE) begin
         state_d     = ST_IDLE;
         resp_data_d = resp_data_q;
         partial_d   = partial_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         data_q       <= '0;
         partial_q    <= '0;
         resp_data_q  <= '0;
         shamnt_q     <= '0;
         op_q         <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         partial_q    <= partial_d;
         resp_data_q  <= resp_data_d;
         shamnt_q     <= shamnt_d;
         op_q         <= op_d;
      end
   end

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign resp0_valid = (state_q == ST_RESP) & ~owner_q;
   assign resp1_valid = (state_q == ST_RESP) &  owner_q;
   assign resp0_data  = resp_data_q;
   assign resp1_data  = resp_data_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
